mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Two-requester arbiter for one Wishbone memory slave (one instance per instruction or data memory), shared between the pipelined core and the UART Wishbone bridge. The core owns the memory by default. A UART request is granted only at a core transaction boundary; while the UART owns the bus, the core is frozen via a stall output. This replaces unarbitrated muxing with a sequenced hand-over that includes bubble cycles and a bus-hang timeout.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
TIMEOUT_CYCLES, 255, maximum cycles a UART strobe waits for a memory ack before a forced ack (minimum 2)
CNT_WIDTH, 16, width of the UART transfer counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_core_req  in  1  core access request (acts as stb)
i_core_we  in  1  core write enable
i_core_adr  in  ADDR_WIDTH  core address
i_core_dat  in  DATA_WIDTH  core write data
i_core_funct3  in  3  core access size
o_core_dat  out  DATA_WIDTH  read data to core
o_core_ack  out  1  core access complete
o_core_stall  out  1  freeze the core pipeline
i_uart_cyc  in  1  bridge cycle
i_uart_stb  in  1  bridge strobe
i_uart_we  in  1  bridge write enable
i_uart_adr  in  ADDR_WIDTH  bridge address
i_uart_dat  in  DATA_WIDTH  bridge write data
o_uart_dat  out  DATA_WIDTH  read data to bridge
o_uart_ack  out  1  bridge ack
o_uart_err  out  1  one-cycle pulse on timeout
o_uart_xfer_cnt  out  CNT_WIDTH  count of completed UART acks
o_mem_cyc, o_mem_stb, o_mem_we  out  1 each  memory bus control
o_mem_adr  out  ADDR_WIDTH  memory address
o_mem_dat  out  DATA_WIDTH  memory write data
o_mem_funct3  out  3  memory access size
i_mem_dat  in  DATA_WIDTH  memory read data
i_mem_ack  in  1  memory ack

Behaviour:
- Reset (async, rst_n=0):
  - state=CORE.
  - o_core_stall=0, o_uart_err=0, o_uart_xfer_cnt=0, timeout counter=0.
  - Combinational outputs follow the CORE-state equations.
  - Reset asserted mid-UART transfer aborts the transfer immediately; no ack is issued.
- Read data: o_core_dat and o_uart_dat are both wired to i_mem_dat at all times.
- CORE state:
  - Memory bus: cyc=stb=i_core_req; we/adr/dat/funct3 taken from the core.
  - o_core_ack=i_mem_ack; o_uart_ack=0.
  - Transition to SWITCH when (i_uart_cyc & i_uart_stb) & (!i_core_req | i_mem_ack).
  - On that same edge, the registered o_core_stall goes to 1.
  - If the core access is still pending, stay in CORE; the UART request keeps waiting.
- SWITCH (exactly 1 cycle):
  - Memory cyc=stb=we=0; o_core_ack=0.
  - Next state: UART.
- UART state:
  - Memory cyc=i_uart_cyc, stb=i_uart_stb; we/adr/dat from the bridge; funct3=3'b010 (word).
  - o_uart_ack=i_mem_ack; o_core_ack=0.
  - Multiple strobes within one cyc are all served.
  - When i_uart_cyc=0 is sampled, go to RELEASE.
- RELEASE (exactly 1 cycle):
  - Bus idle; stall held at 1.
  - Next state: CORE, with o_core_stall cleared on that edge. The core regains the bus on the first CORE cycle.
- Stall summary: o_core_stall=1 for every cycle in SWITCH, UART and RELEASE, and 0 in CORE.
- Timeout (UART state only):
  - The counter increments each cycle with i_uart_stb=1 and i_mem_ack=0; it clears on ack, on stb=0, or on leaving UART.
  - When the counter equals TIMEOUT_CYCLES-1, that cycle asserts o_uart_ack=1 and o_uart_err=1, forces o_mem_stb=0, and clears the counter.
  - A real i_mem_ack arriving on the same cycle takes precedence: ack without err.
- o_uart_xfer_cnt: increments by 1 on every cycle with o_uart_ack=1 (real or forced) and wraps modulo 2^CNT_WIDTH.
- Simultaneous events:
  - UART request arriving in the same cycle as a core ack switches immediately; that core ack still reaches the core.
  - A core request during SWITCH, UART or RELEASE is ignored; the core holds it because it is stalled.
- i_uart_stb without i_uart_cyc never triggers a switch.

Test Plan:
- Reset, idle core: i_core_req=1, adr=0x10, mem acks next cycle -> o_mem_adr=0x10, o_core_ack=1, o_core_stall=0, o_uart_xfer_cnt=0.
- UART write with no core activity: cyc=stb=we=1, adr=0x4, dat=0xCAFEF00D -> stall=1 after 1 edge; SWITCH 1 cycle; o_mem_adr=0x4, o_mem_dat=0xCAFEF00D, o_mem_funct3=3'b010; ack passes to o_uart_ack; cyc drop -> RELEASE -> CORE, stall=0; xfer_cnt=1.
- UART request while core access is pending (ack delayed 3 cycles) -> stays CORE until the core ack; o_core_ack=1 once; then SWITCH.
- Memory never acks a UART strobe, TIMEOUT_CYCLES=8 -> o_uart_ack=o_uart_err=1 exactly 8 cycles after stb rises; o_mem_stb=0 that cycle.
- Burst of 3 UART reads in one cyc, mem data 0x1,0x2,0x3 -> o_uart_dat matches on each ack; xfer_cnt +3; single SWITCH/RELEASE pair.
- rst_n pulled low during UART state -> immediately CORE, stall=0, counters=0; after release, core access at 0x20 succeeds.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the memory arbiter and its environment: core, UART
// bridge and the shared Wishbone memory slave. The arbiter connects through
// the slave modport; the environment connects through the master modport.
interface mem_access_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   // Core side
   logic                  i_core_req;
   logic                  i_core_we;
   logic [ADDR_WIDTH-1:0] i_core_adr;
   logic [DATA_WIDTH-1:0] i_core_dat;
   logic [2:0]            i_core_funct3;
   logic [DATA_WIDTH-1:0] o_core_dat;
   logic                  o_core_ack;
   logic                  o_core_stall;
   // UART bridge side
   logic                  i_uart_cyc;
   logic                  i_uart_stb;
   logic                  i_uart_we;
   logic [ADDR_WIDTH-1:0] i_uart_adr;
   logic [DATA_WIDTH-1:0] i_uart_dat;
   logic [DATA_WIDTH-1:0] o_uart_dat;
   logic                  o_uart_ack;
   logic                  o_uart_err;
   logic [CNT_WIDTH-1:0]  o_uart_xfer_cnt;
   // Memory side
   logic                  o_mem_cyc;
   logic                  o_mem_stb;
   logic                  o_mem_we;
   logic [ADDR_WIDTH-1:0] o_mem_adr;
   logic [DATA_WIDTH-1:0] o_mem_dat;
   logic [2:0]            o_mem_funct3;
   logic [DATA_WIDTH-1:0] i_mem_dat;
   logic                  i_mem_ack;

   modport slave (
      input  i_core_req, i_core_we, i_core_adr, i_core_dat, i_core_funct3,
      output o_core_dat, o_core_ack, o_core_stall,
      input  i_uart_cyc, i_uart_stb, i_uart_we, i_uart_adr, i_uart_dat,
      output o_uart_dat, o_uart_ack, o_uart_err, o_uart_xfer_cnt,
      output o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat, o_mem_funct3,
      input  i_mem_dat, i_mem_ack
   );

   modport master (
      output i_core_req, i_core_we, i_core_adr, i_core_dat, i_core_funct3,
      input  o_core_dat, o_core_ack, o_core_stall,
      output i_uart_cyc, i_uart_stb, i_uart_we, i_uart_adr, i_uart_dat,
      input  o_uart_dat, o_uart_ack, o_uart_err, o_uart_xfer_cnt,
      input  o_mem_cyc, o_mem_stb, o_mem_we, o_mem_adr, o_mem_dat, o_mem_funct3,
      output i_mem_dat, i_mem_ack
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter for one Wishbone memory slave. The core owns the
// memory by default; the UART bridge is granted the bus only at a core
// transaction boundary, with one idle bubble cycle on each hand-over, and the
// core is frozen for the whole UART session. A watchdog forces an ack with an
// error pulse if the memory hangs on a UART strobe.
module mem_access_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_access_arbiter_if.slave bus
);
   localparam int                   TMO_WIDTH   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_WIDTH-1:0] TMO_LAST    = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]           FUNCT3_WORD = 3'b010;

   typedef enum logic [1:0] {
      ST_CORE    = 2'd0,
      ST_SWITCH  = 2'd1,
      ST_UART    = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 stall_q, stall_d;
   logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
   logic                 uart_req;
   logic                 tmo_hit;
   logic                 uart_ack;

   assign uart_req = bus.i_uart_cyc & bus.i_uart_stb;

   // State, stall and counter registers; reset aborts any UART transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_CORE;
         stall_q    <= 1'b0;
         tmo_cnt_q  <= '0;
         xfer_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         stall_q    <= stall_d;
         tmo_cnt_q  <= tmo_cnt_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   // Next-state logic: hand over only at a core transaction boundary.
   always_comb begin
      // NOTE: defaults first so no path through the block can infer a latch.
      state_d = state_q;
      case (state_q)
         ST_CORE:    if (uart_req && (!bus.i_core_req || bus.i_mem_ack)) state_d = ST_SWITCH;
         ST_SWITCH:  state_d = ST_UART;
         ST_UART:    if (!bus.i_uart_cyc) state_d = ST_RELEASE;
         ST_RELEASE: state_d = ST_CORE;
         default:    state_d = ST_CORE;
      endcase
      // Registered stall is high for every cycle outside CORE.
      stall_d = (state_d != ST_CORE);
   end

   // Bus-hang watchdog and completed-transfer counter.
   always_comb begin
      tmo_hit   = (state_q == ST_UART) && bus.i_uart_stb && !bus.i_mem_ack
                  && (tmo_cnt_q == TMO_LAST);
      uart_ack  = (state_q == ST_UART) && (bus.i_mem_ack || tmo_hit);
      tmo_cnt_d = '0;
      if ((state_q == ST_UART) && bus.i_uart_stb && !bus.i_mem_ack && !tmo_hit)
         tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
      xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(uart_ack);
   end

   // Output decode: route the owning requester onto the memory bus.
   always_comb begin
      bus.o_mem_cyc    = 1'b0;
      bus.o_mem_stb    = 1'b0;
      bus.o_mem_we     = 1'b0;
      bus.o_mem_adr    = {ADDR_WIDTH{1'b0}};
      bus.o_mem_dat    = {DATA_WIDTH{1'b0}};
      bus.o_mem_funct3 = 3'b000;
      bus.o_core_ack   = 1'b0;
      bus.o_uart_ack   = 1'b0;
      case (state_q)
         ST_CORE: begin
            bus.o_mem_cyc    = bus.i_core_req;
            bus.o_mem_stb    = bus.i_core_req;
            bus.o_mem_we     = bus.i_core_we;
            bus.o_mem_adr    = bus.i_core_adr;
            bus.o_mem_dat    = bus.i_core_dat;
            bus.o_mem_funct3 = bus.i_core_funct3;
            bus.o_core_ack   = bus.i_mem_ack;
         end
         ST_UART: begin
            bus.o_mem_cyc    = bus.i_uart_cyc;
            bus.o_mem_stb    = bus.i_uart_stb && !tmo_hit;
            bus.o_mem_we     = bus.i_uart_we;
            bus.o_mem_adr    = bus.i_uart_adr;
            bus.o_mem_dat    = bus.i_uart_dat;
            bus.o_mem_funct3 = FUNCT3_WORD;
            bus.o_uart_ack   = uart_ack;
         end
         default: ;
      endcase
   end

   assign bus.o_core_dat      = bus.i_mem_dat;
   assign bus.o_uart_dat      = bus.i_mem_dat;
   assign bus.o_core_stall    = stall_q;
   assign bus.o_uart_err      = tmo_hit;
   assign bus.o_uart_xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed hand-over, timeout,
// burst and reset scenarios followed by randomized traffic, all compared
// every cycle against an ownership-level model of the arbiter.
module tb_mem_access_arbiter;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int CW  = 4;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   mem_access_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_core_req = 1'b0; bus.i_core_we = 1'b0; bus.i_core_adr = '0;
      bus.i_core_dat = '0;   bus.i_core_funct3 = 3'b000;
      bus.i_uart_cyc = 1'b0; bus.i_uart_stb = 1'b0; bus.i_uart_we = 1'b0;
      bus.i_uart_adr = '0;   bus.i_uart_dat = '0;
      bus.i_mem_dat  = '0;   bus.i_mem_ack = 1'b0;
   endtask

   // Ownership model: in_session = core frozen; bubble = bus idle this cycle;
   // closing = the pending bubble returns the bus to the core.
   bit in_session, bubble, closing;
   int unacked;
   int xfers;

   // Compare process: predict every output from the model and current inputs,
   // then advance the model by one clock.
   always @(negedge clk) begin
      int owner;  // 0 core, 1 uart, 2 idle
      bit hit;
      if (!rst_n) begin
         in_session = 0; bubble = 0; closing = 0; unacked = 0; xfers = 0;
         check("rst_stall", bus.o_core_stall, 0);
         check("rst_xfer", bus.o_uart_xfer_cnt, 0);
         check("rst_err", bus.o_uart_err, 0);
         check("rst_uack", bus.o_uart_ack, 0);
         check("rst_cyc", bus.o_mem_cyc, bus.i_core_req);
      end else begin
         owner = !in_session ? 0 : (bubble ? 2 : 1);
         hit   = (owner == 1) && bus.i_uart_stb && !bus.i_mem_ack && (unacked == TMO - 1);
         check("m_stall", bus.o_core_stall, in_session);
         check("m_xfer", bus.o_uart_xfer_cnt, xfers);
         check("m_core_dat", bus.o_core_dat, bus.i_mem_dat);
         check("m_uart_dat", bus.o_uart_dat, bus.i_mem_dat);
         check("m_core_ack", bus.o_core_ack, (owner == 0) && bus.i_mem_ack);
         check("m_uart_ack", bus.o_uart_ack, (owner == 1) && (bus.i_mem_ack || hit));
         check("m_err", bus.o_uart_err, hit);
         if (owner == 0) begin
            check("m_cyc", bus.o_mem_cyc, bus.i_core_req);
            check("m_stb", bus.o_mem_stb, bus.i_core_req);
            check("m_we", bus.o_mem_we, bus.i_core_we);
            check("m_adr", bus.o_mem_adr, bus.i_core_adr);
            check("m_wdat", bus.o_mem_dat, bus.i_core_dat);
            check("m_f3", bus.o_mem_funct3, bus.i_core_funct3);
         end else if (owner == 1) begin
            check("m_cyc", bus.o_mem_cyc, bus.i_uart_cyc);
            check("m_stb", bus.o_mem_stb, bus.i_uart_stb && !hit);
            check("m_we", bus.o_mem_we, bus.i_uart_we);
            check("m_adr", bus.o_mem_adr, bus.i_uart_adr);
            check("m_wdat", bus.o_mem_dat, bus.i_uart_dat);
            check("m_f3", bus.o_mem_funct3, 3'b010);
         end else begin
            check("m_idle", {bus.o_mem_cyc, bus.o_mem_stb, bus.o_mem_we}, 3'b000);
         end
         // advance
         if ((owner == 1) && (bus.i_mem_ack || hit)) xfers = (xfers + 1) % (1 << CW);
         if ((owner == 1) && bus.i_uart_stb && !bus.i_mem_ack && !hit) unacked++;
         else unacked = 0;
         if (owner == 0) begin
            if (bus.i_uart_cyc && bus.i_uart_stb && (!bus.i_core_req || bus.i_mem_ack)) begin
               in_session = 1; bubble = 1; closing = 0;
            end
         end else if (owner == 2) begin
            if (closing) in_session = 0;
            bubble = 0; closing = 0;
         end else if (!bus.i_uart_cyc) begin
            bubble = 1; closing = 1;
         end
      end
   end

   initial begin
      int n;
      bit seen;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Core access right after reset
      step(); bus.i_core_req = 1'b1; bus.i_core_adr = 32'h10;
      @(negedge clk); check("t1_adr", bus.o_mem_adr, 32'h10); check("t1_stb", bus.o_mem_stb, 1);
      step(); bus.i_mem_ack = 1'b1; bus.i_mem_dat = 32'h55;
      @(negedge clk);
      check("t1_ack", bus.o_core_ack, 1); check("t1_stall", bus.o_core_stall, 0);
      check("t1_xfer", bus.o_uart_xfer_cnt, 0); check("t1_dat", bus.o_core_dat, 32'h55);
      step(); idle_inputs();

      // UART write, no core activity
      step(); bus.i_uart_cyc = 1; bus.i_uart_stb = 1; bus.i_uart_we = 1;
      bus.i_uart_adr = 32'h4; bus.i_uart_dat = 32'hCAFEF00D;
      @(negedge clk); check("t2_stall0", bus.o_core_stall, 0);
      step(); @(negedge clk); check("t2_sw_stall", bus.o_core_stall, 1); check("t2_sw_cyc", bus.o_mem_cyc, 0);
      step(); @(negedge clk);
      check("t2_adr", bus.o_mem_adr, 32'h4); check("t2_wdat", bus.o_mem_dat, 32'hCAFEF00D);
      check("t2_f3", bus.o_mem_funct3, 3'b010); check("t2_we", bus.o_mem_we, 1);
      check("t2_noack", bus.o_uart_ack, 0);
      step(); bus.i_mem_ack = 1; @(negedge clk); check("t2_ack", bus.o_uart_ack, 1);
      step(); bus.i_mem_ack = 0; bus.i_uart_cyc = 0; bus.i_uart_stb = 0; bus.i_uart_we = 0;
      @(negedge clk); check("t2_drop_stall", bus.o_core_stall, 1);
      step(); @(negedge clk); check("t2_rel_stall", bus.o_core_stall, 1); check("t2_rel_cyc", bus.o_mem_cyc, 0);
      step(); @(negedge clk); check("t2_core_stall", bus.o_core_stall, 0); check("t2_xfer", bus.o_uart_xfer_cnt, 1);

      // UART request while a core access is pending
      step(); bus.i_core_req = 1; bus.i_core_adr = 32'h30; bus.i_uart_cyc = 1; bus.i_uart_stb = 1;
      bus.i_uart_adr = 32'h8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_wait_stall", bus.o_core_stall, 0); check("t3_wait_ack", bus.o_core_ack, 0);
         check("t3_wait_adr", bus.o_mem_adr, 32'h30);
         step();
      end
      bus.i_mem_ack = 1; @(negedge clk);
      check("t3_core_ack", bus.o_core_ack, 1); check("t3_stall", bus.o_core_stall, 0);
      step(); bus.i_mem_ack = 0; @(negedge clk);
      check("t3_sw_stall", bus.o_core_stall, 1); check("t3_sw_ack", bus.o_core_ack, 0);
      step(); bus.i_mem_ack = 1; bus.i_mem_dat = 32'h77; @(negedge clk);
      check("t3_uack", bus.o_uart_ack, 1); check("t3_udat", bus.o_uart_dat, 32'h77);
      check("t3_no_core_ack", bus.o_core_ack, 0);
      step(); bus.i_mem_ack = 0; bus.i_uart_cyc = 0; bus.i_uart_stb = 0;
      step(); step(); bus.i_core_req = 0; @(negedge clk);
      check("t3_stall_end", bus.o_core_stall, 0); check("t3_xfer", bus.o_uart_xfer_cnt, 2);

      // Timeout: memory never acks a strobe
      step(); bus.i_uart_cyc = 1; bus.i_uart_stb = 1; bus.i_uart_adr = 32'hC;
      step(); step(); bus.i_mem_ack = 1; bus.i_mem_dat = 32'h11;
      @(negedge clk); check("t4_first_ack", bus.o_uart_ack, 1); check("t4_first_err", bus.o_uart_err, 0);
      step(); bus.i_mem_ack = 0; bus.i_uart_stb = 0;
      step(); bus.i_uart_stb = 1;
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk); n++;
         if (bus.o_uart_err) seen = 1; else step();
      end
      check("t4_tmo_cycles", n, TMO);
      check("t4_stb_low", bus.o_mem_stb, 0); check("t4_forced_ack", bus.o_uart_ack, 1);
      step(); bus.i_uart_cyc = 0; bus.i_uart_stb = 0;
      @(negedge clk); check("t4_err_pulse", bus.o_uart_err, 0);
      step(); step(); @(negedge clk);
      check("t4_xfer", bus.o_uart_xfer_cnt, 4); check("t4_stall", bus.o_core_stall, 0);

      // Burst of three reads in one cycle
      step(); bus.i_uart_cyc = 1; bus.i_uart_stb = 1; bus.i_uart_adr = 32'h40;
      step(); step();
      for (int k = 1; k <= 3; k++) begin
         bus.i_uart_stb = 1;
         @(negedge clk); check("t5_wait", bus.o_uart_ack, 0);
         step(); bus.i_mem_ack = 1; bus.i_mem_dat = k;
         @(negedge clk);
         check("t5_ack", bus.o_uart_ack, 1); check("t5_dat", bus.o_uart_dat, k);
         check("t5_stall", bus.o_core_stall, 1);
         step(); bus.i_mem_ack = 0; bus.i_uart_stb = 0; bus.i_uart_adr += 4;
         @(negedge clk); check("t5_gap_stall", bus.o_core_stall, 1);
         step();
      end
      bus.i_uart_cyc = 0;
      step(); step(); @(negedge clk);
      check("t5_xfer", bus.o_uart_xfer_cnt, 7); check("t5_stall_end", bus.o_core_stall, 0);

      // Reset during UART ownership
      step(); bus.i_uart_cyc = 1; bus.i_uart_stb = 1;
      step(); step();
      #3 rst_n = 1'b0;
      #1;
      check("t6_stall", bus.o_core_stall, 0); check("t6_xfer", bus.o_uart_xfer_cnt, 0);
      check("t6_uack", bus.o_uart_ack, 0); check("t6_cyc", bus.o_mem_cyc, 0);
      bus.i_uart_cyc = 0; bus.i_uart_stb = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.i_core_req = 1; bus.i_core_adr = 32'h20;
      @(negedge clk); check("t6_adr", bus.o_mem_adr, 32'h20); check("t6_stall_after", bus.o_core_stall, 0);
      step(); bus.i_mem_ack = 1; @(negedge clk); check("t6_core_ack", bus.o_core_ack, 1);
      step(); idle_inputs();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.i_core_req    = ($urandom_range(0, 1) == 1);
         bus.i_core_we     = $urandom_range(0, 1);
         bus.i_core_adr    = $urandom;
         bus.i_core_dat    = $urandom;
         bus.i_core_funct3 = 3'($urandom_range(0, 7));
         if (bus.i_uart_cyc) bus.i_uart_cyc = ($urandom_range(0, 9) != 0);
         else                bus.i_uart_cyc = ($urandom_range(0, 3) == 0);
         bus.i_uart_stb = ($urandom_range(0, 3) != 0);
         bus.i_uart_we  = $urandom_range(0, 1);
         bus.i_uart_adr = $urandom;
         bus.i_uart_dat = $urandom;
         bus.i_mem_dat  = $urandom;
         bus.i_mem_ack  = ($urandom_range(0, 3) == 0);
      end
      step(); idle_inputs();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
